// File: rtl/display_source_arbiter_if.sv
// Handshake bundle between the display requesters, the arbiter and the 7-segment serializer.
// The arbiter takes the slave view; the producer/serializer side takes the master view.
interface display_source_arbiter_if #(
    parameter int NUM_REQ = 3
) ();
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    grant;
    logic [15:0]           disp_data;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [1:0]            cur_src;
    logic                  busy;

    modport master (
        output req,
        output req_data,
        output disp_ready,
        input  grant,
        input  disp_data,
        input  disp_valid,
        input  cur_src,
        input  busy
    );

    modport slave (
        input  req,
        input  req_data,
        input  disp_ready,
        output grant,
        output disp_data,
        output disp_valid,
        output cur_src,
        output busy
    );
endinterface

// File: rtl/display_source_arbiter.sv
// Round-robin arbiter sharing one 4-digit BCD display among up to three sources,
// with a minimum on-screen hold per frame and a one-shot default frame after idling.
module display_source_arbiter #(
    parameter int          NUM_REQ      = 3,
    parameter int          HOLD_CYCLES  = 1000,
    parameter int          IDLE_TIMEOUT = 50000,
    parameter logic [15:0] DEFAULT_BCD  = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst,
    display_source_arbiter_if.slave   bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > IDLE_TIMEOUT) ? HOLD_CYCLES : IDLE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDLE_SAT    = CNT_W'(IDLE_TIMEOUT);
    localparam logic [1:0]       LAST_SRC    = 2'(NUM_REQ - 1);
    localparam logic [1:0]       DEFAULT_SRC = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    state_t             state_reg;
    logic [1:0]         rr_ptr_reg;
    logic [CNT_W-1:0]   idle_cnt_reg;
    logic [CNT_W-1:0]   hold_cnt_reg;
    logic               default_shown_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [15:0]        disp_data_reg;
    logic               disp_valid_reg;
    logic [1:0]         cur_src_reg;
    logic               busy_reg;

    // Sources padded out to four slots so the scan can always use a 2-bit index.
    logic [3:0]  req_pad;
    logic [15:0] src_data [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            if (gi < NUM_REQ) begin : g_used
                assign req_pad[gi]  = bus.req[gi];
                assign src_data[gi] = bus.req_data[16*gi +: 16];
            end else begin : g_unused
                assign req_pad[gi]  = 1'b0;
                assign src_data[gi] = 16'h0000;
            end
        end
    endgenerate

    logic       pick_found;
    logic [1:0] pick_idx;
    logic [2:0] scan_sum;
    logic [3:0] pick_onehot;
    logic [1:0] rr_ptr_next;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        scan_sum   = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_reg} + 3'(k);
            if (scan_sum >= 3'(NUM_REQ)) begin
                scan_sum = scan_sum - 3'(NUM_REQ);
            end
            if (!pick_found && req_pad[scan_sum[1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_sum[1:0];
            end
        end
    end

    assign pick_onehot = 4'b0001 << pick_idx;
    assign rr_ptr_next = (pick_idx == LAST_SRC) ? 2'd0 : pick_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            rr_ptr_reg        <= 2'd0;
            idle_cnt_reg      <= '0;
            hold_cnt_reg      <= '0;
            default_shown_reg <= 1'b0;
            grant_reg         <= '0;
            disp_data_reg     <= 16'h0000;
            disp_valid_reg    <= 1'b0;
            cur_src_reg       <= DEFAULT_SRC;
            busy_reg          <= 1'b0;
        end else begin
            grant_reg <= '0;
            case (state_reg)
                IDLE: begin
                    // A live request always beats an expiring idle timer.
                    if (pick_found) begin
                        disp_data_reg     <= src_data[pick_idx];
                        grant_reg         <= pick_onehot[NUM_REQ-1:0];
                        disp_valid_reg    <= 1'b1;
                        cur_src_reg       <= pick_idx;
                        rr_ptr_reg        <= rr_ptr_next;
                        idle_cnt_reg      <= '0;
                        default_shown_reg <= 1'b0;
                        busy_reg          <= 1'b1;
                        state_reg         <= SEND;
                    end else if (idle_cnt_reg == IDLE_LAST && !default_shown_reg) begin
                        disp_data_reg     <= DEFAULT_BCD;
                        disp_valid_reg    <= 1'b1;
                        cur_src_reg       <= DEFAULT_SRC;
                        idle_cnt_reg      <= '0;
                        default_shown_reg <= 1'b1;
                        busy_reg          <= 1'b1;
                        state_reg         <= SEND;
                    end else if (idle_cnt_reg != IDLE_SAT) begin
                        idle_cnt_reg <= idle_cnt_reg + CNT_ONE;
                    end
                end
                SEND: begin
                    if (bus.disp_ready) begin
                        disp_valid_reg <= 1'b0;
                        hold_cnt_reg   <= '0;
                        state_reg      <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    disp_valid_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                    state_reg      <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = grant_reg;
    assign bus.disp_data  = disp_data_reg;
    assign bus.disp_valid = disp_valid_reg;
    assign bus.cur_src    = cur_src_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Bench for display_source_arbiter: round-robin vector table plus hand-written
// sequences for latency, idle default, collision, backpressure and reset.
module tb_display_source_arbiter;

    localparam int NUM_REQ = 3;
    localparam int HOLD    = 4;
    localparam int IDLE_TO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_source_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    display_source_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .HOLD_CYCLES  (HOLD),
        .IDLE_TIMEOUT (IDLE_TO),
        .DEFAULT_BCD  (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
    } frame_t;
    frame_t sb_q[$];

    typedef struct {
        logic [2:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [2:0]  exp_grant;
        logic [1:0]  exp_src;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2);
        bus.req      = r;
        bus.req_data = {d2, d1, d0};
    endtask

    task automatic expect_frame(input logic [15:0] d, input logic [1:0] s);
        frame_t f;
        f.data = d;
        f.src  = s;
        sb_q.push_back(f);
    endtask

    // After this returns, the current cycle is the first one out of reset (cycle 0).
    task automatic do_reset();
        chk("sb_drained_before_reset", 32'(sb_q.size()), 32'd0);
        rst            = 1'b1;
        bus.disp_ready = 1'b1;
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        step(2);
        rst = 1'b0;
    endtask

    // Scoreboard: every accepted frame must match the oldest expected one.
    frame_t mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.disp_valid && bus.disp_ready) begin
                $display("frame accepted cyc=%0d src=%0d data=%h", cyc, bus.cur_src, bus.disp_data);
                chk("sb_frame_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_exp = sb_q.pop_front();
                    chk("sb_data", 32'(bus.disp_data), 32'(mon_exp.data));
                    chk("sb_src", 32'(bus.cur_src), 32'(mon_exp.src));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int quiet_cnt;
    int last_grant_cyc;
    int w;

    initial begin
        bus.req        = '0;
        bus.req_data   = '0;
        bus.disp_ready = 1'b1;

        vecs[0] = '{3'b111, 16'hC012, 16'hE050, 16'hD1A5, 3'b001, 2'd0, 16'hC012};
        vecs[1] = '{3'b111, 16'hC012, 16'hE050, 16'hD1A5, 3'b010, 2'd1, 16'hE050};
        vecs[2] = '{3'b111, 16'hC012, 16'hE050, 16'hD1A5, 3'b100, 2'd2, 16'hD1A5};
        vecs[3] = '{3'b111, 16'hC012, 16'hE050, 16'hD1A5, 3'b001, 2'd0, 16'hC012};
        vecs[4] = '{3'b101, 16'h1111, 16'h2222, 16'h3333, 3'b100, 2'd2, 16'h3333};
        vecs[5] = '{3'b110, 16'h4444, 16'h5555, 16'h6666, 3'b010, 2'd1, 16'h5555};
        vecs[6] = '{3'b011, 16'h7777, 16'h8888, 16'h9999, 3'b001, 2'd0, 16'h7777};
        vecs[7] = '{3'b100, 16'h0123, 16'h0456, 16'h0987, 3'b100, 2'd2, 16'h0987};

        // Reset values, then the idle default frame at cycle 10.
        do_reset();
        chk("rst_valid", 32'(bus.disp_valid), 32'd0);
        chk("rst_cur_src", 32'(bus.cur_src), 32'd3);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_data", 32'(bus.disp_data), 32'd0);
        expect_frame(16'hFFFF, 2'd3);
        step(9);
        chk("idle_no_early_default", 32'(bus.disp_valid), 32'd0);
        step(1);
        chk("default_frame", 32'({bus.disp_valid, bus.cur_src, bus.grant, bus.disp_data}),
            32'({1'b1, 2'd3, 3'b000, 16'hFFFF}));
        step(1);
        quiet_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            quiet_cnt += int'(bus.disp_valid);
        end
        chk("no_second_default", 32'(quiet_cnt), 32'd0);
        drive(3'b010, 16'h0000, 16'h0042, 16'h0000);
        expect_frame(16'h0042, 2'd1);
        expect_frame(16'hFFFF, 2'd3);
        step(1);
        chk("rearm_grant", 32'(bus.grant), 32'b010);
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        step(14);
        chk("rearm_default_not_yet", 32'(bus.disp_valid), 32'd0);
        step(1);
        chk("rearm_default", 32'({bus.disp_valid, bus.cur_src, bus.disp_data}),
            32'({1'b1, 2'd3, 16'hFFFF}));
        step(6);

        // Single request: grant one cycle after req, hold 4 cycles, idle again.
        do_reset();
        step(5);
        chk("t1_no_grant_yet", 32'(bus.grant), 32'd0);
        drive(3'b001, 16'hC012, 16'h0000, 16'h0000);
        expect_frame(16'hC012, 2'd0);
        step(1);
        chk("t1_grant", 32'({bus.grant, bus.disp_valid, bus.busy, bus.cur_src}),
            32'({3'b001, 1'b1, 1'b1, 2'd0}));
        chk("t1_data", 32'(bus.disp_data), 32'hC012);
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < HOLD; i++) begin
            step(1);
            chk("t1_hold", 32'({bus.busy, bus.disp_valid, bus.grant}), 32'({1'b1, 1'b0, 3'b000}));
        end
        step(1);
        chk("t1_idle", 32'(bus.busy), 32'd0);

        // Round-robin vector table, next request applied on the first idle cycle.
        do_reset();
        last_grant_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            expect_frame(vecs[i].exp_data, vecs[i].exp_src);
            step(1);
            chk($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(vecs[i].exp_grant));
            chk($sformatf("tbl%0d_src", i), 32'(bus.cur_src), 32'(vecs[i].exp_src));
            chk($sformatf("tbl%0d_data", i), 32'(bus.disp_data), 32'(vecs[i].exp_data));
            if (i > 0) chk($sformatf("tbl%0d_spacing", i), 32'(cyc - last_grant_cyc), 32'd6);
            last_grant_cyc = cyc;
            drive(3'b000, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            w = 0;
            while (bus.busy && w < 20) begin
                step(1);
                w++;
            end
            chk($sformatf("tbl%0d_busy_cycles", i), 32'(w), 32'(HOLD + 1));
        end

        // Request arriving on the timeout cycle wins over the default frame.
        do_reset();
        step(9);
        drive(3'b100, 16'h0000, 16'h0000, 16'hD250);
        expect_frame(16'hD250, 2'd2);
        step(1);
        chk("col_frame", 32'({bus.disp_valid, bus.grant, bus.cur_src, bus.disp_data}),
            32'({1'b1, 3'b100, 2'd2, 16'hD250}));
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        step(6);

        // Backpressure: frame held stable while the serializer stalls.
        do_reset();
        bus.disp_ready = 1'b0;
        drive(3'b001, 16'hC064, 16'h0000, 16'h0000);
        expect_frame(16'hC064, 2'd0);
        step(1);
        chk("bp_grant", 32'(bus.grant), 32'b001);
        drive(3'b011, 16'h0000, 16'h0999, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("bp_stable", 32'({bus.disp_valid, bus.busy, bus.grant, bus.disp_data}),
                32'({1'b1, 1'b1, 3'b000, 16'hC064}));
        end
        bus.disp_ready = 1'b1;
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        step(1);
        chk("bp_hold", 32'({bus.disp_valid, bus.busy}), 32'({1'b0, 1'b1}));
        step(4);
        chk("bp_idle", 32'(bus.busy), 32'd0);

        // Reset while stalled in SEND, then a pending request uses fresh priority.
        do_reset();
        bus.disp_ready = 1'b0;
        drive(3'b010, 16'h0000, 16'h00A5, 16'h0000);
        step(1);
        chk("r6_grant_first", 32'(bus.grant), 32'b010);
        step(3);
        rst = 1'b1;
        drive(3'b101, 16'h0777, 16'h0000, 16'h0333);
        step(1);
        chk("r6_after_rst", 32'({bus.disp_valid, bus.cur_src, bus.busy, bus.grant}),
            32'({1'b0, 2'd3, 1'b0, 3'b000}));
        rst            = 1'b0;
        bus.disp_ready = 1'b1;
        expect_frame(16'h0777, 2'd0);
        step(1);
        chk("r6_pending", 32'({bus.grant, bus.cur_src, bus.disp_data}),
            32'({3'b001, 2'd0, 16'h0777}));
        drive(3'b000, 16'h0, 16'h0, 16'h0);
        step(5);
        chk("sb_drained_at_end", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
